// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
// Shares the single main-memory read port between the I-cache and D-cache
// fill FSMs. One requester owns the port at a time; each word beat is one
// read strobe followed by a wait for the memory's data-valid, which is routed
// only to the owner. The grant is released after BEATS_PER_BLOCK beats, or
// early when the owner withdraws its miss.
//
// Build option: define ARB_ROUND_ROBIN_EN to alternate between the caches
// when both miss together. Without it the D-cache always wins a tie.
module cache_mem_arbiter #(
  parameter int BEATS_PER_BLOCK = 8,
  parameter int BEAT_CNT_W      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        icache_miss,
  input  logic [15:0] icache_addr,
  input  logic        dcache_miss,
  input  logic [15:0] dcache_addr,
  input  logic        mem_data_valid,
  output logic        mem_enable,
  output logic [15:0] mem_addr,
  output logic        icache_data_valid,
  output logic        dcache_data_valid,
  output logic        icache_grant,
  output logic        dcache_grant
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BEATS_PER_BLOCK);

  logic [1:0]            state, state_nxt;
  logic                  owner, owner_nxt;        // 0 = I-cache, 1 = D-cache
  logic [BEAT_CNT_W-1:0] beat_cnt, beat_cnt_nxt;

  logic        owner_miss;
  logic [15:0] owner_addr;
  logic        granted;
  logic        pick_d;
  logic        beat_valid;

  assign owner_miss = owner ? dcache_miss : icache_miss;
  assign owner_addr = owner ? dcache_addr : icache_addr;
  assign granted    = (state == ISSUE) || (state == WAIT);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner;

  // Tie-break: the cache that did not hold the port last time wins.
  always_comb begin
    if (icache_miss && dcache_miss) pick_d = ~last_owner;
    else                            pick_d = dcache_miss;
  end

  // Remember who held the port at every release back to IDLE.
  always_ff @(posedge clk) begin
    if (rst)                              last_owner <= 1'b0;
    else if (granted && state_nxt == IDLE) last_owner <= owner;
  end
`else
  // Tie-break: the D-cache always wins; a lone requester is taken as-is.
  always_comb begin
    pick_d = dcache_miss;
  end
`endif

  // Next-state: grant on any miss, one strobe per beat, release after the
  // last beat or when the owner has withdrawn its miss.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    state_nxt    = state;
    owner_nxt    = owner;
    beat_cnt_nxt = beat_cnt;
    case (state)
      IDLE: begin
        if (icache_miss || dcache_miss) begin
          owner_nxt    = pick_d;
          beat_cnt_nxt = '0;
          state_nxt    = ISSUE;
        end
      end
      ISSUE: begin
        // A withdrawn miss releases the port without strobing memory.
        state_nxt = owner_miss ? WAIT : IDLE;
      end
      WAIT: begin
        // The outstanding read must complete before the port moves on, even
        // if the owner aborted; such a beat is counted but not routed, and
        // the following ISSUE sees the dropped miss and releases.
        if (mem_data_valid) begin
          beat_cnt_nxt = beat_cnt + 1'b1;
          state_nxt    = (beat_cnt_nxt == LAST_BEAT) ? IDLE : ISSUE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State registers; reset abandons any fill, and a read still in flight
  // then arrives outside WAIT and is ignored.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so each one samples the
    // pre-edge values regardless of statement order.
    if (rst) begin
      state    <= IDLE;
      owner    <= 1'b0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  // Outputs are decoded from the registered state plus the live miss, so the
  // strobe and the routed valid land in the same cycle as their cause.
  assign beat_valid        = (state == WAIT) && mem_data_valid && owner_miss;
  assign mem_enable        = (state == ISSUE) && owner_miss;
  assign mem_addr          = mem_enable ? owner_addr : 16'h0000;
  assign icache_data_valid = beat_valid && !owner;
  assign dcache_data_valid = beat_valid && owner;
  assign icache_grant      = granted && !owner;
  assign dcache_grant      = granted && owner;

endmodule
